// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, register offsets and frame constants for the UART transmitter
package uart_pkg;

    localparam int          DATA_BITS  = 8;
    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two byte FIFO between the store port and the serialiser
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full  = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];

    // pointers wrap naturally since DEPTH is a power of two; push+pop together keeps count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    end

    // storage needs no reset: empty/full flags gate every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_stage.sv
// uart_tx_stage: memory-mapped UART transmitter with store-stall handshake (define UART_TX_PARITY_EN for an even-parity bit)
module uart_tx_stage
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          DEPTH        = 4,
    parameter logic [31:0] UART_BASE    = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memw,
    input  logic        memr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        pipe_en,
    output logic        tx,
    output logic        tx_clk,
    output logic        Ff,
    output logic        Fe,
    output logic        busy,
    output logic        done_t
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam int            BW   = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_e            state;
    tx_state_e            state_n;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] dout;
    logic                 push;
    logic                 pop;
    logic                 sel_tx;
    logic                 sel_st;
    logic                 wdata_unused;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    assign wdata_unused = ^wdata[31:8];
    assign sel_tx  = memw && (addr == UART_BASE + TXDATA_OFS);
    assign sel_st  = memr && (addr == UART_BASE + STATUS_OFS);
    assign push    = sel_tx && (!Ff || pop);
    assign pipe_en = !(sel_tx && Ff && !pop);
    assign rdata   = sel_st ? {29'b0, busy, Ff, Fe} : 32'b0;
    assign busy    = state != IDLE;
    assign tx_clk  = cnt == LAST;
    assign done_t  = (state == STOP) && tx_clk;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wdata[DATA_BITS-1:0]),
        .dout  (dout),
        .full  (Ff),
        .empty (Fe)
    );

    // serial line driven straight from state so reset returns it to mark at once
    always_comb begin
`ifdef UART_TX_PARITY_EN
        tx = (state == START) ? 1'b0 : (state == DATA) ? sh[0] : (state == PARITY) ? par : 1'b1;
`else
        tx = (state == START) ? 1'b0 : (state == DATA) ? sh[0] : 1'b1;
`endif
    end

    // next state and FIFO pop; the last stop cycle chains straight into the next start
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                pop     = !Fe;
                state_n = Fe ? IDLE : START;
            end
            START:  state_n = tx_clk ? DATA : START;
`ifdef UART_TX_PARITY_EN
            DATA:   state_n = (tx_clk && bit_idx == LAST_BIT) ? PARITY : DATA;
            PARITY: state_n = tx_clk ? STOP : PARITY;
`else
            DATA:   state_n = (tx_clk && bit_idx == LAST_BIT) ? STOP : DATA;
`endif
            STOP: begin
                pop     = tx_clk && !Fe;
                state_n = !tx_clk ? STOP : Fe ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, baud counter (parked at 0 in IDLE) and LSB-first shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state == IDLE || tx_clk) ? '0 : cnt + 1'b1;
            if (pop) begin
                sh      <= dout;
                bit_idx <= '0;
            end else if (state == DATA && tx_clk) begin
                sh      <= sh >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // even parity captured with the byte so shifting does not disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par <= 1'b0;
        else if (pop) par <= ^dout;
    end
`endif

endmodule

// File: tb/tb_uart_tx_stage.sv
// tb_uart_tx_stage: directed scoreboard bench for uart_tx_stage (CLKS_PER_BIT=4, DEPTH=4)
module tb_uart_tx_stage;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0000_0400;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        memw;
    logic        memr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        pipe_en;
    logic        tx;
    logic        tx_clk;
    logic        Ff;
    logic        Fe;
    logic        busy;
    logic        done_t;

    int          checks = 0;
    int          failures = 0;
    int          frames = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          grp_n = 0;
    int          prev_start = 0;
    bit          mon_en = 1'b0;
    bit          b2b_chk = 1'b0;
    logic [7:0]  sb [$];

    uart_tx_stage #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (4),
        .UART_BASE    (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .memw    (memw),
        .memr    (memr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .pipe_en (pipe_en),
        .tx      (tx),
        .tx_clk  (tx_clk),
        .Ff      (Ff),
        .Fe      (Fe),
        .busy    (busy),
        .done_t  (done_t)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done_t === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] d, input bit track, output int stalls);
        int n = 0;
        @(negedge clk);
        memw = 1'b1;
        addr = a;
        wdata = {24'hABCDEF, d};
        #1;
        while (pipe_en !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("store_accept", pipe_en, 1);
        if (track && a == BASE && pipe_en === 1'b1) sb.push_back(d);
        @(posedge clk);
        #1;
        memw = 1'b0;
        stalls = n;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy === 1'b0 && Fe === 1'b1) && n < 2000);
        check("idle_reached", n < 2000, 1);
        repeat (2) @(negedge clk);
    endtask

    // one frame decoded from its first START sample; every bit must hold for CPB samples
    task automatic rx_frame();
        logic [7:0]    exp;
        logic [NB-1:0] frm;
        logic [CPB-1:0] s;
        logic          d = 1'b0;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        exp = sb.pop_front();
        if (b2b_chk) begin
            if (grp_n > 0) check("no_gap", cyc - prev_start, NB * CPB);
            grp_n++;
            prev_start = cyc;
        end
        frm[0] = 1'b0;
        frm[8:1] = exp;
`ifdef UART_TX_PARITY_EN
        frm[9] = ^exp;
`endif
        frm[NB-1] = 1'b1;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                s[c] = tx;
                if (b == NB - 1 && c == CPB - 1) d = done_t;
            end
            check($sformatf("tx_bit%0d_%02h", b, exp), s, {CPB{frm[b]}});
        end
        check("done_last_stop", d, 1);
        frames++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b1 && tx === 1'b0) rx_frame();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int dc;
        rst = 1'b0;
        memw = 1'b0;
        memr = 1'b0;
        addr = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        memr = 1'b1;
        addr = BASE + 32'h4;
        #1;
        check("rst_tx", tx, 1);
        check("rst_fe", Fe, 1);
        check("rst_ff", Ff, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_t, 0);
        check("rst_txclk", tx_clk, 0);
        check("rst_pipe_en", pipe_en, 1);
        check("rst_status", rdata, 32'h1);
        memr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        store(BASE, 8'hA5, 1'b1, st);
        check("idle_before_start", tx, 1);
        @(posedge clk);
        #1;
        check("start_after_e1", tx, 0);
        check("busy_in_frame", busy, 1);
        wait_idle();
        check("a5_fe_after", Fe, 1);
        check("a5_busy_after", busy, 0);
        check("a5_one_done", done_cnt, 1);

        store(BASE + 32'h4, 8'h11, 1'b1, st);
        store(BASE - 32'h4, 8'h22, 1'b1, st);
        repeat (3) @(negedge clk);
        check("badaddr_fe", Fe, 1);
        check("badaddr_busy", busy, 0);

        b2b_chk = 1'b1;
        grp_n = 0;
        store(BASE, 8'h01, 1'b1, st);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) store(BASE, 8'h10 + 8'(i * 8'h11), 1'b1, st);
        check("ff_after_4", Ff, 1);
        check("fe_after_4", Fe, 0);
        store(BASE, 8'hC3, 1'b1, st);
        check("fifth_stalled", st > 0, 1);
        wait_idle();
        check("b2b_frames", grp_n, 6);
        b2b_chk = 1'b0;

        store(BASE, 8'h5A, 1'b1, st);
        store(BASE, 8'h3C, 1'b1, st);
        store(BASE, 8'hF0, 1'b1, st);
        memr = 1'b1;
        addr = BASE + 32'h4;
        #1;
        check("status_2q", rdata, 32'h4);
        addr = BASE + 32'h8;
        #1;
        check("status_badaddr", rdata, 32'h0);
        addr = BASE + 32'h4;
        memr = 1'b0;
        #1;
        check("status_noread", rdata, 32'h0);
        wait_idle();

        mon_en = 1'b0;
        store(BASE, 8'h35, 1'b0, st);
        store(BASE, 8'h5A, 1'b0, st);
        repeat (17) @(posedge clk);
        #1;
        check("pre_rst_bit3", tx, 0);
        check("pre_rst_busy", busy, 1);
        dc = done_cnt;
        rst = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_fe", Fe, 1);
        check("abort_ff", Ff, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done_t, 0);
        check("abort_txclk", tx_clk, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        check("abort_line_idle", tx, 1);
        mon_en = 1'b1;
        store(BASE, 8'h96, 1'b1, st);
        wait_idle();

        store(BASE, 8'h07, 1'b1, st);
        wait_idle();

        check("sb_drained", sb.size(), 0);
        check("frame_count", frames, 12);
        check("done_count", done_cnt, frames);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
